// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufarb_if.sv
// Request/data/grant bundle between the requesters and the shared-driver arbiter.
// The arbiter's sequencing and drive behaviour live in gf180mcu_fd_sc_mcu9t5v0__bufarb.
interface gf180mcu_fd_sc_mcu9t5v0__bufarb_if #(
    parameter int N = 4
);
    logic [N-1:0] REQ;
    logic [N-1:0] I;
    logic [N-1:0] GNT;
    logic         Z;
    logic         BUSY;

    modport master (output REQ, output I, input GNT, input Z, input BUSY);
    modport slave  (input REQ, input I, output GNT, output Z, output BUSY);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__bufarb.sv
// Round-robin owner sequencing for a shared buffered driver, with min/max tenure and a dead cycle.
// GF180MCU_FD_SC_MCU9T5V0__BUFARB_PARK_EN: Z parks on the last owner's bit outside GRANT instead of 0.
module gf180mcu_fd_sc_mcu9t5v0__bufarb #(
    parameter int N        = 4,
    parameter int HOLD_MIN = 2,
    parameter int HOLD_MAX = 16
) (
    input  logic CLK,
    input  logic RST,
    gf180mcu_fd_sc_mcu9t5v0__bufarb_if.slave bus
);
    // state   | meaning
    // S_IDLE  | no owner, arbitrate on any REQ
    // S_GRANT | owner drives Z, tenure counting
    // S_TURN  | one dead cycle between owners, arbitrate again
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_TURN} state_t;

    localparam int         OW    = (N > 1) ? $clog2(N) : 1;
    localparam logic [8:0] L_MIN = 9'(HOLD_MIN);
    localparam logic [8:0] L_MAX = 9'(HOLD_MAX);

    state_t          r_state, w_state_nxt;
    logic [OW-1:0]   r_owner, w_owner_nxt;
    logic [OW-1:0]   r_last, w_last_nxt;
    logic [7:0]      r_ten, w_ten_nxt;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic            r_busy;
    logic [OW-1:0]   w_pick;
    logic [OW-1:0]   w_idx;
    logic            w_any;
    logic [8:0]      w_ten_p1;
    logic            w_release;
    logic            w_z_idle;

    // Search upward from last+1 so the most recent owner ranks lowest.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_idx  = '0;
        for (int k = 1; k <= N; k++) begin
            w_idx = OW'((int'(r_last) + k) % N);
            if (!w_any && bus.REQ[w_idx]) begin
                w_any  = 1'b1;
                w_pick = w_idx;
            end
        end
    end

    assign w_ten_p1  = {1'b0, r_ten} + 9'd1;
    assign w_release = ((!bus.REQ[r_owner]) && (w_ten_p1 >= L_MIN)) || (w_ten_p1 == L_MAX);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_ten_nxt   = r_ten;
        case (r_state)
            S_IDLE, S_TURN: begin
                if (w_any) begin
                    w_state_nxt = S_GRANT;
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    w_ten_nxt   = '0;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_GRANT: begin
                if (w_release) begin
                    w_state_nxt = S_TURN;
                end else begin
                    w_ten_nxt = (w_ten_p1 >= L_MAX) ? L_MAX[7:0] : w_ten_p1[7:0];
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_gnt_nxt = '0;
        if (w_state_nxt == S_GRANT) begin
            w_gnt_nxt[w_owner_nxt] = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_owner <= '0;
            r_last  <= OW'(N - 1);
            r_ten   <= '0;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_ten   <= w_ten_nxt;
            r_gnt   <= w_gnt_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

`ifdef GF180MCU_FD_SC_MCU9T5V0__BUFARB_PARK_EN
    logic r_z_park;

    // Keeps the shared line at its last driven level so the handover does not glitch.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_z_park <= 1'b0;
        end else if (r_state == S_GRANT) begin
            r_z_park <= bus.I[r_owner];
        end
    end

    assign w_z_idle = r_z_park;
`else
    assign w_z_idle = 1'b0;
`endif

    assign bus.GNT  = r_gnt;
    assign bus.BUSY = r_busy;
    assign bus.Z    = (r_state == S_GRANT) ? bus.I[r_owner] : w_z_idle;
endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__bufarb.sv
// Scenario and randomized checks of the shared-driver arbiter against a tenure-based reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__bufarb;
    localparam int N    = 4;
    localparam int HMIN = 2;
    localparam int HMAX = 16;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    gf180mcu_fd_sc_mcu9t5v0__bufarb_if #(.N(N)) bus();

    gf180mcu_fd_sc_mcu9t5v0__bufarb #(.N(N), .HOLD_MIN(HMIN), .HOLD_MAX(HMAX)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

`ifdef GF180MCU_FD_SC_MCU9T5V0__BUFARB_PARK_EN
    localparam bit PARK = 1'b1;
`else
    localparam bit PARK = 1'b0;
`endif

    // Reference: who owns the line, how many cycles it has held it, whether a dead cycle is running.
    int           m_owner = -1;
    int           m_held_cycles = 0;
    int           m_last = N - 1;
    bit           m_dead = 1'b0;
    logic         m_park = 1'b0;
    logic [N-1:0] drv_req = '0;
    logic [N-1:0] drv_i = '0;

    function automatic void model_edge();
        int cand;
        if (RST) begin
            m_owner = -1; m_held_cycles = 0; m_last = N - 1; m_dead = 1'b0; m_park = 1'b0;
        end else if (m_owner >= 0) begin
            m_park = drv_i[m_owner];
            m_held_cycles++;
            if (m_held_cycles >= HMAX || (!drv_req[m_owner] && m_held_cycles >= HMIN)) begin
                m_owner = -1;
                m_dead  = 1'b1;
            end
        end else begin
            m_dead = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = (m_last + k) % N;
                if (m_owner < 0 && drv_req[cand]) begin
                    m_owner = cand;
                    m_last  = cand;
                    m_held_cycles = 0;
                end
            end
        end
    endfunction

    function automatic logic [N-1:0] exp_gnt();
        logic [N-1:0] one = 1;
        return (m_owner < 0) ? '0 : (one << m_owner);
    endfunction

    function automatic logic exp_busy();
        return (m_owner >= 0) || m_dead;
    endfunction

    function automatic logic exp_z();
        if (m_owner >= 0) return drv_i[m_owner];
        return PARK ? m_park : 1'b0;
    endfunction

    task automatic tick(input logic [N-1:0] req, input logic [N-1:0] din, input logic rst);
        drv_req = req; drv_i = din;
        bus.REQ = req; bus.I = din; RST = rst;
        @(posedge CLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b1);
        checks++;
        if (bus.GNT !== '0 || bus.BUSY !== 1'b0 || bus.Z !== 1'b0) begin
            failures++;
            $display("FAIL reset_state gnt=%b busy=%b z=%b required gnt=0000 busy=0 z=0", bus.GNT, bus.BUSY, bus.Z);
        end
        for (int c = 0; c < 5; c++) begin
            tick('0, N'($urandom_range(0, 15)), 1'b0);
            checks++;
            if (bus.GNT !== '0 || bus.BUSY !== 1'b0 || bus.Z !== 1'b0) begin
                failures++;
                $display("FAIL idle_quiet cyc=%0d gnt=%b busy=%b z=%b required all zero", c, bus.GNT, bus.BUSY, bus.Z);
            end
        end
    endtask

    task automatic test_all_request();
        int order[$];
        int run_len = 0, gap_len = 0, runs_done = 0;
        logic [N-1:0] prev = '0;
        bit started = 1'b0;
        tick('0, '0, 1'b1);
        for (int c = 0; c < 72; c++) begin
            tick('1, N'($urandom_range(0, 15)), 1'b0);
            checks++;
            if (bus.GNT !== exp_gnt() || bus.Z !== exp_z() || bus.BUSY !== exp_busy()) begin
                failures++;
                $display("FAIL all_req cyc=%0d gnt=%b z=%b busy=%b required gnt=%b z=%b busy=%b",
                         c, bus.GNT, bus.Z, bus.BUSY, exp_gnt(), exp_z(), exp_busy());
            end
            if (bus.GNT != '0 && prev == '0) begin
                for (int b = 0; b < N; b++) if (bus.GNT[b]) order.push_back(b);
                if (started) begin
                    checks++;
                    if (gap_len != 1) begin
                        failures++;
                        $display("FAIL all_req_gap got=%0d required=1", gap_len);
                    end
                end
                started = 1'b1; run_len = 1;
            end else if (bus.GNT != '0) begin
                run_len++;
            end else if (prev != '0) begin
                runs_done++; gap_len = 1;
                checks++;
                if (run_len != HMAX) begin
                    failures++;
                    $display("FAIL all_req_tenure got=%0d required=%0d", run_len, HMAX);
                end
            end else begin
                gap_len++;
            end
            prev = bus.GNT;
        end
        checks++;
        if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
            failures++;
            $display("FAIL all_req_order got=%p required=0,1,2,3,0", order);
        end
    endtask

    task automatic test_pulse_and_park();
        tick('0, '0, 1'b1);
        tick('0, '0, 1'b0);
        tick(4'b0100, 4'b0000, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0100 || bus.Z !== 1'b0 || bus.BUSY !== 1'b1) begin
            failures++;
            $display("FAIL pulse_first gnt=%b z=%b busy=%b required gnt=0100 z=0 busy=1", bus.GNT, bus.Z, bus.BUSY);
        end
        drv_i = 4'b0100; bus.I = 4'b0100;
        #1;
        checks++;
        if (bus.Z !== 1'b1) begin
            failures++;
            $display("FAIL pulse_z_track got=%b required=1", bus.Z);
        end
        tick(4'b0000, 4'b0100, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0100 || bus.Z !== 1'b1) begin
            failures++;
            $display("FAIL pulse_min_hold gnt=%b z=%b required gnt=0100 z=1", bus.GNT, bus.Z);
        end
        tick(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b1 || bus.Z !== PARK) begin
            failures++;
            $display("FAIL pulse_turn gnt=%b busy=%b z=%b required gnt=0000 busy=1 z=%b", bus.GNT, bus.BUSY, bus.Z, PARK);
        end
        tick(4'b0000, 4'b0000, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.Z !== PARK) begin
            failures++;
            $display("FAIL pulse_idle gnt=%b busy=%b z=%b required gnt=0000 busy=0 z=%b", bus.GNT, bus.BUSY, bus.Z, PARK);
        end
    endtask

    task automatic test_rr_release();
        int held = 0;
        bit released = 1'b0;
        tick('0, '0, 1'b1);
        tick(4'b0010, '0, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0010) begin
            failures++;
            $display("FAIL rr_first got=%b required=0010", bus.GNT);
        end
        held = 1;
        for (int c = 0; c < 40 && !released; c++) begin
            tick(4'b0011, '0, 1'b0);
            if (bus.GNT == '0) released = 1'b1;
            else held++;
        end
        checks++;
        if (!released || held != HMAX) begin
            failures++;
            $display("FAIL rr_forced_release released=%0d held=%0d required held=%0d", released, held, HMAX);
        end
        tick(4'b0011, '0, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0001) begin
            failures++;
            $display("FAIL rr_next_owner got=%b required=0001", bus.GNT);
        end
    endtask

    task automatic test_reset_mid_grant();
        tick('0, '0, 1'b1);
        tick(4'b1000, 4'b1000, 1'b0);
        tick(4'b1000, 4'b1000, 1'b0);
        checks++;
        if (bus.GNT !== 4'b1000 || bus.Z !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_setup gnt=%b z=%b required gnt=1000 z=1", bus.GNT, bus.Z);
        end
        tick(4'b1000, 4'b1000, 1'b1);
        checks++;
        if (bus.GNT !== 4'b0000 || bus.BUSY !== 1'b0 || bus.Z !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_drop gnt=%b busy=%b z=%b required all zero", bus.GNT, bus.BUSY, bus.Z);
        end
        tick(4'b1001, 4'b0000, 1'b0);
        checks++;
        if (bus.GNT !== 4'b0001) begin
            failures++;
            $display("FAIL rst_mid_priority got=%b required=0001", bus.GNT);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] req;
        tick('0, '0, 1'b1);
        for (int c = 0; c < 800; c++) begin
            req = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            tick(req, N'($urandom_range(0, 15)), ($urandom_range(0, 60) == 0));
            checks++;
            if (bus.GNT !== exp_gnt() || bus.Z !== exp_z() || bus.BUSY !== exp_busy()) begin
                failures++;
                $display("FAIL random cyc=%0d gnt=%b z=%b busy=%b required gnt=%b z=%b busy=%b",
                         c, bus.GNT, bus.Z, bus.BUSY, exp_gnt(), exp_z(), exp_busy());
            end
        end
    endtask

    initial begin
        bus.REQ = '0;
        bus.I   = '0;
        test_reset();
        test_all_request();
        test_pulse_and_park();
        test_rr_release();
        test_reset_mid_grant();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
